// File: rtl/render_pkg.sv
// Shared constants and types for the tile pixel renderer.
// Screen geometry, tile map sizing, palette types and the clear/run state encoding.
package render_pkg;

    localparam int H_SIZE    = 1600;
    localparam int V_SIZE    = 900;
    localparam int TILE_LOG2 = 4;
    localparam int TILE_PX   = 1 << TILE_LOG2;
    localparam int TILES_X   = (H_SIZE + TILE_PX - 1) / TILE_PX;
    localparam int TILES_Y   = (V_SIZE + TILE_PX - 1) / TILE_PX;
    localparam int MAP_DEPTH = TILES_X * TILES_Y;
    localparam int MAP_AW    = $clog2(MAP_DEPTH);
    localparam int PAL_DEPTH = 16;

    typedef logic [3:0]        pal_idx_t;
    typedef logic [23:0]       rgb_t;
    typedef logic [MAP_AW-1:0] map_addr_t;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } render_state_e;

    // Power-up palette: black everywhere except white in the last entry.
    function automatic rgb_t pal_reset_value(input pal_idx_t idx);
        return (idx == 4'hF) ? 24'hFFFFFF : 24'h000000;
    endfunction

endpackage

// File: rtl/tile_map_ram.sv
// Simple dual-port tile map storage: one write port, one registered read port.
// No reset on the array or read register so it maps onto block RAM.
// A read and write to the same address in one cycle returns the previous contents.
module tile_map_ram
    import render_pkg::*;
#(
    parameter int DEPTH = MAP_DEPTH,
    parameter int AW    = MAP_AW,
    parameter int DW    = 4
)
(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [DW-1:0] mem [DEPTH];

    // Write (dropping addresses past the end of the map) and registered read.
    always_ff @(posedge clk) begin
        if (we && (waddr <= LAST_ADDR)) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/tile_pixel_renderer.sv
// Tile-based colour source for the VGA timing stage.
// Maps a 1-based (h,v) request to a tile index, looks up its palette index in the
// tile map RAM and returns the palette colour exactly two cycles later.
// After reset the whole tile map is cleared before normal operation starts.
// The palette is double buffered; the shadow copy commits on the i_valid falling edge.
// Optional build macro RENDER_CURSOR_EN: overlays a 16x16 cursor drawn in palette entry 15.
module tile_pixel_renderer
    import render_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [11:0] i_h,
    input  logic [10:0] i_v,
    input  logic        i_valid,
    output logic [23:0] o_color,
    input  logic        i_map_we,
    input  logic [12:0] i_map_addr,
    input  logic [3:0]  i_map_data,
    input  logic        i_pal_we,
    input  logic [3:0]  i_pal_addr,
    input  logic [23:0] i_pal_data,
    output logic        o_pal_pending,
    output logic        o_busy,
    input  logic [10:0] i_cursor_x,
    input  logic [9:0]  i_cursor_y
);

    localparam map_addr_t CLR_LAST = map_addr_t'(MAP_DEPTH - 1);

    render_state_e state, state_nx;
    map_addr_t     clr_addr;
    logic          busy;
    logic          ram_we;
    map_addr_t     ram_waddr;
    pal_idx_t      ram_wdata;

    rgb_t          shadow_pal [PAL_DEPTH];
    rgb_t          active_pal [PAL_DEPTH];
    logic          pal_pending;
    logic          valid_prev;
    logic          commit;

    logic          in_range_p0;
    logic          vld_p0;
    map_addr_t     addr_p0;
    logic [11:0]   col_p0;
    logic [10:0]   row_p0;
    logic          vld_p1;
    pal_idx_t      idx_p1;
    rgb_t          color_p1;

    // State register for the clear/run sequencer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= CLEAR;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and RAM write-port steering: the clear walk owns the port while busy.
    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        ram_we    = i_map_we;
        ram_waddr = i_map_addr;
        ram_wdata = i_map_data;
        unique case (state)
            CLEAR: begin
                busy      = 1'b1;
                ram_we    = 1'b1;
                ram_waddr = clr_addr;
                ram_wdata = '0;
                if (clr_addr == CLR_LAST) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                state_nx = RUN;
            end
            default: begin
                state_nx = CLEAR;
            end
        endcase
    end

    // Clear address walks 0..MAP_DEPTH-1, one entry per cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clr_addr <= '0;
        end else if (state == CLEAR) begin
            clr_addr <= clr_addr + map_addr_t'(1);
        end
    end

    assign o_busy = busy;

    // ---- C0: coordinate check and tile address (combinational) ----
    assign in_range_p0 = (i_h >= 12'd1) && (i_h <= 12'(H_SIZE)) &&
                         (i_v >= 11'd1) && (i_v <= 11'(V_SIZE));
    assign vld_p0      = i_valid && in_range_p0 && (state == RUN);
    assign col_p0      = (i_h - 12'd1) >> TILE_LOG2;
    assign row_p0      = (i_v - 11'd1) >> TILE_LOG2;
    assign addr_p0     = map_addr_t'(row_p0) * map_addr_t'(TILES_X) + map_addr_t'(col_p0);

    // ---- C1: registered tile map read ----
    tile_map_ram #(
        .DEPTH (MAP_DEPTH),
        .AW    (MAP_AW),
        .DW    (4)
    ) u_map (
        .clk   (i_clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (vld_p0),
        .raddr (addr_p0),
        .rdata (idx_p1)
    );

    // Valid follows the RAM read by one stage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
        end
    end

`ifdef RENDER_CURSOR_EN
    logic [12:0] h_ext_p0;
    logic [11:0] v_ext_p0;
    logic        hit_p0;
    logic        hit_p1;

    // The cursor is a fixed 16x16 square anchored at its top-left pixel.
    assign h_ext_p0 = {1'b0, i_h};
    assign v_ext_p0 = {1'b0, i_v};
    assign hit_p0   = (h_ext_p0 >= {2'b0, i_cursor_x}) && (h_ext_p0 <= {2'b0, i_cursor_x} + 13'd15) &&
                      (v_ext_p0 >= {2'b0, i_cursor_y}) && (v_ext_p0 <= {2'b0, i_cursor_y} + 12'd15);

    // Cursor hit travels alongside the tile read.
    always_ff @(posedge i_clk) begin
        hit_p1 <= hit_p0;
    end

    assign color_p1 = hit_p1 ? active_pal[PAL_DEPTH-1] : active_pal[idx_p1];
`else
    logic cursor_unused;
    assign cursor_unused = ^{i_cursor_x, i_cursor_y};
    assign color_p1      = active_pal[idx_p1];
`endif

    // ---- C2: palette lookup, invalid pixels are black ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_color <= '0;
        end else if (!vld_p1) begin
            o_color <= '0;
        end else begin
            o_color <= color_p1;
        end
    end

    // End of frame is the cycle in which i_valid has just dropped.
    assign commit = valid_prev && !i_valid && pal_pending;

    // Frame-edge tracking and the pending flag; a write during commit keeps it set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_prev  <= 1'b0;
            pal_pending <= 1'b0;
        end else begin
            valid_prev <= i_valid;
            if (i_pal_we) begin
                pal_pending <= 1'b1;
            end else if (commit) begin
                pal_pending <= 1'b0;
            end
        end
    end

    assign o_pal_pending = pal_pending;

    // Shadow palette takes game-logic writes at any time.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < PAL_DEPTH; k++) begin
                shadow_pal[k] <= pal_reset_value(pal_idx_t'(k));
            end
        end else if (i_pal_we) begin
            shadow_pal[i_pal_addr] <= i_pal_data;
        end
    end

    // Active palette copies the shadow only at commit, merging a same-cycle write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < PAL_DEPTH; k++) begin
                active_pal[k] <= pal_reset_value(pal_idx_t'(k));
            end
        end else if (commit) begin
            for (int k = 0; k < PAL_DEPTH; k++) begin
                active_pal[k] <= (i_pal_we && (i_pal_addr == pal_idx_t'(k))) ? i_pal_data : shadow_pal[k];
            end
        end
    end

endmodule

// File: tb/tb_tile_pixel_renderer.sv
// Directed bench for tile_pixel_renderer: reset/clear timing, tile lookup latency,
// palette double buffering, RAM collision behaviour and out-of-range handling.
module tb_tile_pixel_renderer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] h = '0;
    logic [10:0] v = '0;
    logic        valid = 1'b0;
    logic [23:0] color;
    logic        map_we = 1'b0;
    logic [12:0] map_addr = '0;
    logic [3:0]  map_data = '0;
    logic        pal_we = 1'b0;
    logic [3:0]  pal_addr = '0;
    logic [23:0] pal_data = '0;
    logic        pal_pending;
    logic        busy;
    logic [10:0] cursor_x = 11'd100;
    logic [9:0]  cursor_y = 10'd50;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] h;
        logic [10:0] v;
        logic        vld;
        logic [23:0] exp;
    } vec_t;

    localparam int NVEC = 17;
    vec_t tbl [NVEC];

`ifdef RENDER_CURSOR_EN
    localparam logic [23:0] EXP_CUR_A = 24'hFFFFFF;
    localparam logic [23:0] EXP_CUR_B = 24'hFFFFFF;
`else
    localparam logic [23:0] EXP_CUR_A = 24'h12AB34;
    localparam logic [23:0] EXP_CUR_B = 24'h000000;
`endif

    tile_pixel_renderer dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_h           (h),
        .i_v           (v),
        .i_valid       (valid),
        .o_color       (color),
        .i_map_we      (map_we),
        .i_map_addr    (map_addr),
        .i_map_data    (map_data),
        .i_pal_we      (pal_we),
        .i_pal_addr    (pal_addr),
        .i_pal_data    (pal_data),
        .o_pal_pending (pal_pending),
        .o_busy        (busy),
        .i_cursor_x    (cursor_x),
        .i_cursor_y    (cursor_y)
    );

    always #5 clk = ~clk;

    task automatic check_rgb(input string name, input logic [23:0] got, input logic [23:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Counts rising edges until busy drops, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 8000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic map_wr(input logic [12:0] a, input logic [3:0] d);
        @(negedge clk);
        map_we = 1'b1; map_addr = a; map_data = d;
        @(negedge clk);
        map_we = 1'b0;
    endtask

    task automatic pal_wr(input logic [3:0] a, input logic [23:0] d);
        @(negedge clk);
        pal_we = 1'b1; pal_addr = a; pal_data = d;
        @(negedge clk);
        pal_we = 1'b0;
    endtask

    // Request one pixel and compare the colour two cycles later.
    task automatic px(input logic [11:0] hh, input logic [10:0] vv, input logic [23:0] want, input string name);
        @(negedge clk);
        h = hh; v = vv; valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_rgb(name, color, want);
    endtask

    // One-cycle drop of i_valid marks the end of a frame.
    task automatic frame_end();
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        valid = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;

        tbl[0]  = '{12'd17,   11'd17,  1'b1, 24'h12AB34};
        tbl[1]  = '{12'd16,   11'd16,  1'b1, 24'h000000};
        tbl[2]  = '{12'd32,   11'd32,  1'b1, 24'h12AB34};
        tbl[3]  = '{12'd33,   11'd17,  1'b1, 24'h000000};
        tbl[4]  = '{12'd17,   11'd33,  1'b1, 24'h000000};
        tbl[5]  = '{12'd1,    11'd17,  1'b1, 24'h12AB34};
        tbl[6]  = '{12'd1600, 11'd900, 1'b1, 24'h00FF7F};
        tbl[7]  = '{12'd1,    11'd897, 1'b1, 24'h00FF7F};
        tbl[8]  = '{12'd1600, 11'd1,   1'b1, 24'hFFFFFF};
        tbl[9]  = '{12'd1601, 11'd1,   1'b1, 24'h000000};
        tbl[10] = '{12'd1,    11'd901, 1'b1, 24'h000000};
        tbl[11] = '{12'd17,   11'd17,  1'b0, 24'h000000};
        tbl[12] = '{12'd20,   11'd20,  1'b1, 24'h12AB34};
        tbl[13] = '{12'd100,  11'd50,  1'b1, EXP_CUR_A};
        tbl[14] = '{12'd115,  11'd65,  1'b1, EXP_CUR_B};
        tbl[15] = '{12'd116,  11'd50,  1'b1, 24'h000000};
        tbl[16] = '{12'd99,   11'd50,  1'b1, 24'h12AB34};

        repeat (3) @(negedge clk);
        check_rgb("rst_color", color, 24'h000000);
        check_bit("rst_busy", busy, 1'b1);
        check_bit("rst_pending", pal_pending, 1'b0);

        rst_n = 1'b1;
        count_busy(n);
        check_int("clear_cycles", n, 5700);

        px(12'd1, 11'd1, 24'h000000, "first_px");

        map_wr(13'd101, 4'd3);
        map_wr(13'd100, 4'd3);
        map_wr(13'd5699, 4'd7);
        map_wr(13'd5600, 4'd7);
        map_wr(13'd99, 4'd15);
        map_wr(13'd306, 4'd3);
        px(12'd1600, 11'd1, 24'hFFFFFF, "reset_pal15");

        pal_wr(4'd3, 24'h12AB34);
        pal_wr(4'd7, 24'h00FF7F);
        pal_wr(4'd5, 24'h0000AA);
        @(negedge clk);
        check_bit("pending_set", pal_pending, 1'b1);
        px(12'd17, 11'd17, 24'h000000, "shadow_not_live");
        frame_end();
        check_bit("pending_clr", pal_pending, 1'b0);

        // Back-to-back stream: each result must appear exactly two cycles after its request.
        for (int i = 0; i < NVEC + 2; i++) begin
            @(negedge clk);
            if (i >= 2) check_rgb($sformatf("vec%0d", i - 2), color, tbl[i-2].exp);
            if (i < NVEC) begin
                h = tbl[i].h; v = tbl[i].v; valid = tbl[i].vld;
            end else begin
                h = 12'd1; v = 11'd1; valid = 1'b1;
            end
        end

        pal_wr(4'd0, 24'hFF0000);
        px(12'd16, 11'd16, 24'h000000, "pal0_midframe");
        check_bit("pal0_pending", pal_pending, 1'b1);
        frame_end();
        check_bit("pal0_committed", pal_pending, 1'b0);
        px(12'd16, 11'd16, 24'hFF0000, "pal0_next_frame");
        px(12'd1601, 11'd1, 24'h000000, "oob_black");

        // Write and read tile 0 in the same cycle.
        @(negedge clk);
        h = 12'd1; v = 11'd1; valid = 1'b1;
        map_we = 1'b1; map_addr = 13'd0; map_data = 4'd5;
        @(negedge clk);
        map_we = 1'b0;
        @(negedge clk);
        check_rgb("rw_old_data", color, 24'hFF0000);
        @(negedge clk);
        check_rgb("rw_new_data", color, 24'h0000AA);

        map_wr(13'd5700, 4'd9);
        map_wr(13'd8191, 4'd9);
        px(12'd1600, 11'd900, 24'h00FF7F, "oob_wr_last_tile");
        px(12'd1, 11'd1, 24'h0000AA, "oob_wr_first_tile");

        // Shadow write landing in the commit cycle.
        pal_wr(4'd1, 24'h111111);
        map_wr(13'd1, 4'd2);
        map_wr(13'd2, 4'd1);
        @(negedge clk);
        valid = 1'b0;
        pal_we = 1'b1; pal_addr = 4'd2; pal_data = 24'h222222;
        @(negedge clk);
        valid = 1'b1;
        pal_we = 1'b0;
        check_bit("commit_keep_pending", pal_pending, 1'b1);
        px(12'd17, 11'd1, 24'h222222, "commit_merged_write");
        px(12'd33, 11'd1, 24'h111111, "commit_shadow_copy");
        frame_end();
        check_bit("pending_clr2", pal_pending, 1'b0);

        // Reset in the middle of the clear walk restarts it from the beginning.
        map_wr(13'd101, 4'd15);
        @(negedge clk);
        valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2000) @(posedge clk);
        @(negedge clk);
        check_bit("busy_at_2000", busy, 1'b1);
        rst_n = 1'b0;
        #2;
        check_bit("busy_in_reset", busy, 1'b1);
        check_rgb("color_in_reset", color, 24'h000000);
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(n);
        check_int("reclear_cycles", n, 5700);
        px(12'd17, 11'd17, 24'h000000, "map_cleared");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
